// File: rtl/net_host_ctrl_pkg.sv
// Shared types and constants for the net_proc host-side sequencer.
// A 784-byte image pads to 810 bytes (30 chunks of 27) before the run starts.
package net_host_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        PAD,
        START,
        RUN,
        RESULT
    } net_ctrl_state_t;

    localparam logic [3:0] NET_ERR_IDX = 4'hF;

    localparam int IMG_BYTES_DEF   = 784;
    localparam int CHUNK_BYTES_DEF = 27;
    localparam int RUN_TIMEOUT_DEF = 2**20;

    function automatic int pad_bytes(input int img_bytes, input int chunk_bytes);
        return (chunk_bytes - img_bytes % chunk_bytes) % chunk_bytes;
    endfunction

endpackage

// File: rtl/net_host_ctrl.sv
// Host sequencer: streams one image into net_proc data memory, pads it to a
// whole chunk, starts the network and returns its classification or a timeout.
module net_host_ctrl
    import net_host_ctrl_pkg::*;
#(
    parameter int IMG_BYTES   = IMG_BYTES_DEF,
    parameter int CHUNK_BYTES = CHUNK_BYTES_DEF,
    parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [3:0] m_data,
    output logic       m_err,
    output logic       busy,
    output logic       np_start,
    input  logic       np_done,
    input  logic [3:0] np_max_idx,
    output logic       mem_rst,
    output logic       mem_we,
    output logic [7:0] mem_wdata
);

    localparam int PAD_BYTES = pad_bytes(IMG_BYTES, CHUNK_BYTES);
    localparam int BCW       = $clog2(IMG_BYTES + 1);
    localparam int RCW       = $clog2(RUN_TIMEOUT);

    localparam logic [BCW-1:0] IMG_LAST = BCW'(IMG_BYTES - 1);
    localparam logic [BCW-1:0] PAD_LAST = BCW'((PAD_BYTES > 0) ? PAD_BYTES - 1 : 0);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_TIMEOUT - 1);

    net_ctrl_state_t r_state;
    net_ctrl_state_t w_next;

    logic [BCW-1:0] r_byte_cnt;
    logic [RCW-1:0] r_run_cnt;
    logic [3:0]     r_m_data;
    logic           r_m_err;

    logic w_img_last;
    logic w_pad_last;
    logic w_run_last;

    assign w_img_last = (r_byte_cnt == IMG_LAST);
    assign w_pad_last = (r_byte_cnt == PAD_LAST);
    assign w_run_last = (r_run_cnt == RUN_LAST);

    // NOTE: synchronous state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the default assignment before the case keeps this block purely
    // combinational; any path leaving w_next unassigned would infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (s_valid) w_next = CLEAR;
            CLEAR:   w_next = LOAD;
            LOAD:    if (s_valid && w_img_last) w_next = (PAD_BYTES == 0) ? START : PAD;
            PAD:     if (w_pad_last) w_next = START;
            START:   w_next = RUN;
            RUN:     if (np_done || w_run_last) w_next = RESULT;
            RESULT:  if (m_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // byte_cnt is shared: it counts image bytes in LOAD and pad bytes in PAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_run_cnt  <= '0;
            r_m_data   <= '0;
            r_m_err    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (s_valid) r_byte_cnt <= w_img_last ? '0 : r_byte_cnt + BCW'(1);
                end
                PAD: begin
                    r_byte_cnt <= w_pad_last ? '0 : r_byte_cnt + BCW'(1);
                end
                RUN: begin
                    if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + RCW'(1);
                    if (np_done) begin
                        r_m_data <= np_max_idx;
                        r_m_err  <= 1'b0;
                    end else if (w_run_last) begin
                        r_m_data <= NET_ERR_IDX;
                        r_m_err  <= 1'b1;
                    end
                end
                RESULT: ;
                default: begin
                    r_byte_cnt <= '0;
                    r_run_cnt  <= '0;
                end
            endcase
        end
    end

    // All handshake and memory controls decode from the registered state, so
    // m_valid never depends on m_ready and the write port idles outside LOAD/PAD.
    assign s_ready   = (r_state == LOAD);
    assign mem_we    = ((r_state == LOAD) && s_valid) || (r_state == PAD);
    assign mem_wdata = (r_state == LOAD) ? s_data : 8'h00;
    assign mem_rst   = (r_state == CLEAR);
    assign np_start  = (r_state == START);
    assign m_valid   = (r_state == RESULT);
    assign busy      = (r_state != IDLE);
    assign m_data    = r_m_data;
    assign m_err     = r_m_err;

endmodule
